// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: memory-side PC/instruction, redirect, decode handshake
interface fetch_unit_if;
    logic        fetch_en;
    logic [15:0] pc;
    logic [39:0] instr_in;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_instr;
    logic [15:0] out_pc;
    logic        fault;

    modport master (
        input  fetch_en, instr_in, redirect_valid, redirect_target, out_ready,
        output pc, out_valid, out_instr, out_pc, fault
    );

    modport slave (
        output fetch_en, instr_in, redirect_valid, redirect_target, out_ready,
        input  pc, out_valid, out_instr, out_pc, fault
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC sequencing, redirect/fault handling, {pc, instr} queue to decode
module fetch_unit #(
    parameter int          PROG_DEPTH  = 256,
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [15:0] RESET_PC    = 16'd0
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam logic [CW-1:0] QD_C     = CW'(QUEUE_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(QUEUE_DEPTH - 1);
    localparam logic [16:0]   PD_C     = 17'(PROG_DEPTH);
    localparam logic [15:0]   LAST_PC  = 16'(PROG_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t        state, state_next;
    logic [15:0]   pc_q, pc_next;
    logic [15:0]   q_pc    [QUEUE_DEPTH];
    logic [39:0]   q_instr [QUEUE_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          fault_q;
    logic          out_valid_c, pop, push, redirect_ok, redirect_bad;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_next   = state;
        pc_next      = pc_q;
        redirect_ok  = 1'b0;
        redirect_bad = 1'b0;
        push         = 1'b0;
        out_valid_c  = (count != '0) && (state != FAULT);
        pop          = out_valid_c && bus.out_ready;

        // Once faulted, redirects are ignored until reset.
        if (state != FAULT && bus.redirect_valid) begin
            if ({1'b0, bus.redirect_target} < PD_C) redirect_ok  = 1'b1;
            else                                    redirect_bad = 1'b1;
        end

        unique case (state)
            IDLE:    if (bus.fetch_en)  state_next = RUN;
            RUN:     if (!bus.fetch_en) state_next = IDLE;
            default: state_next = FAULT;
        endcase
        if (redirect_bad) state_next = FAULT;

        push = (state == RUN) && !redirect_ok && !redirect_bad && ((count < QD_C) || pop);

        if (redirect_ok)  pc_next = bus.redirect_target;
        else if (push)    pc_next = (pc_q == LAST_PC) ? 16'd0 : pc_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
            if (redirect_bad) fault_q <= 1'b1;
            // A pop coincident with a flush is still consumed; the flush simply empties the rest.
            if (redirect_ok || redirect_bad) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= next_ptr(tail);
                if (pop)  head <= next_ptr(head);
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]    <= pc_q;
            q_instr[tail] <= bus.instr_in;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.out_valid = out_valid_c;
    assign bus.out_pc    = out_valid_c ? q_pc[head]    : 16'd0;
    assign bus.out_instr = out_valid_c ? q_instr[head] : 40'd0;
    assign bus.fault     = fault_q;
endmodule
